// File: rtl/c1_bus_slave.sv
// C1 bus slave: decodes a two-beat C1 request, hands one request to the cache core over
// valid/ready, then drives the code-7 response (and read data) back onto the shared bus.
module c1_bus_slave #(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                         data,
    inout  wire  [2:0]                                  command,
    output logic                                        req_valid,
    input  logic                                        req_ready,
    output logic [2:0]                                  req_cmd,
    output logic [MEM_ADDR_SIZE-1:0]                    req_addr,
    output logic [2*BUS_SIZE-1:0]                       req_wdata,
    input  logic                                        rsp_valid,
    input  logic [2*BUS_SIZE-1:0]                       rsp_rdata
);

    localparam int TS_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

    localparam logic [2:0] C_RD8  = 3'd1;
    localparam logic [2:0] C_RD16 = 3'd2;
    localparam logic [2:0] C_RD32 = 3'd3;
    localparam logic [2:0] C_WR8  = 3'd5;
    localparam logic [2:0] C_WR16 = 3'd6;
    localparam logic [2:0] C_WR32 = 3'd7;
    localparam logic [2:0] C_RESP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR2,
        S_REQ,
        S_WAIT,
        S_RESP_LO,
        S_RESP_HI
    } state_t;

    state_t                   state, state_next;
    logic [2:0]               cmd_q;
    logic [TS_W-1:0]          tag_set_q;
    logic [CACHE_OFFSET_SIZE-1:0] offset_q;
    logic [BUS_SIZE-1:0]      wlo_q, whi_q;
    logic [2*BUS_SIZE-1:0]    rdata_q;

    logic                     cmd_hit;
    logic                     drive_cmd;
    logic                     drive_data;
    logic [BUS_SIZE-1:0]      data_out;

    // Undriven or unknown command lines are a NOP, as is code 0.
    assign cmd_hit = !$isunknown(command) && (command != 3'd0);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            tag_set_q <= '0;
            offset_q  <= '0;
            wlo_q     <= '0;
            whi_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (cmd_hit) begin
                        cmd_q     <= command;
                        tag_set_q <= address;
                        wlo_q     <= data;
                    end
                end
                S_ADDR2: begin
                    offset_q <= address[CACHE_OFFSET_SIZE-1:0];
                    whi_q    <= data;
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        rdata_q <= rsp_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        drive_cmd  = 1'b0;
        drive_data = 1'b0;
        data_out   = '0;
        case (state)
            S_IDLE:  if (cmd_hit) state_next = S_ADDR2;
            S_ADDR2: state_next = S_REQ;
            S_REQ: begin
                req_valid = 1'b1;
                if (req_ready) state_next = S_WAIT;
            end
            S_WAIT:  if (rsp_valid) state_next = S_RESP_LO;
            S_RESP_LO: begin
                drive_cmd  = 1'b1;
                state_next = (cmd_q == C_RD32) ? S_RESP_HI : S_IDLE;
                case (cmd_q)
                    C_RD8: begin
                        drive_data = 1'b1;
                        data_out   = {{(BUS_SIZE-8){1'b0}}, rdata_q[7:0]};
                    end
                    C_RD16, C_RD32: begin
                        drive_data = 1'b1;
                        data_out   = rdata_q[BUS_SIZE-1:0];
                    end
                    default: ;
                endcase
            end
            S_RESP_HI: begin
                drive_cmd  = 1'b1;
                drive_data = 1'b1;
                data_out   = rdata_q[2*BUS_SIZE-1:BUS_SIZE];
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_wdata = '0;
        case (cmd_q)
            C_WR8:   req_wdata = {{(2*BUS_SIZE-8){1'b0}}, wlo_q[7:0]};
            C_WR16:  req_wdata = {{BUS_SIZE{1'b0}}, wlo_q};
            C_WR32:  req_wdata = {whi_q, wlo_q};
            default: req_wdata = '0;
        endcase
    end

    assign req_cmd  = cmd_q;
    assign req_addr = {tag_set_q, offset_q};

    // The slave only drives the shared lines while responding; IDLE/ADDR2 belong to the master.
    assign command = drive_cmd  ? C_RESP   : 3'bzzz;
    assign data    = drive_data ? data_out : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_c1_bus_slave.sv
// Directed bench for c1_bus_slave: a master/core model drives C1 transactions and a
// scoreboard of expected requests and response beats is checked as the slave produces them.
module tb_c1_bus_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] address;
    wire  [15:0] data;
    wire  [2:0]  command;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    logic        m_oe;
    logic [2:0]  m_cmd;
    logic [15:0] m_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [15:0] beat_q[$];

    // Master side of the shared lines; released lines are pulled low so they read as 0.
    assign command = m_oe ? m_cmd  : 3'bzzz;
    assign data    = m_oe ? m_data : 16'hzzzz;
    pulldown pd_cmd (command);
    pulldown pd_data (data);

    always #5 clk = ~clk;

    c1_bus_slave dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data      (data),
        .command   (command),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [15:0] lo,
                                                input logic [15:0] hi);
        case (c)
            3'd5:    return {24'h0, lo[7:0]};
            3'd6:    return {16'h0, lo};
            3'd7:    return {hi, lo};
            default: return 32'h0;
        endcase
    endfunction

    // Expected bus data per response cycle; non-read responses leave data released (pulled to 0).
    task automatic push_beats(input logic [2:0] c, input logic [31:0] rd);
        case (c)
            3'd1:    beat_q.push_back({8'h00, rd[7:0]});
            3'd2:    beat_q.push_back(rd[15:0]);
            3'd3: begin
                beat_q.push_back(rd[15:0]);
                beat_q.push_back(rd[31:16]);
            end
            default: beat_q.push_back(16'h0000);
        endcase
    endtask

    task automatic idle_cycles(input int n, input bit stray, input bit drive_nop);
        for (int i = 0; i < n; i++) begin
            m_oe      = drive_nop;
            m_cmd     = 3'd0;
            m_data    = 16'h0;
            rsp_valid = stray;
            rsp_rdata = 32'hCAFE_F00D;
            @(negedge clk);
            rsp_valid = 1'b0;
            check("idle_req_valid", {31'b0, req_valid}, 32'd0);
            if (!drive_nop) begin
                check("idle_cmd_released", {29'b0, command}, 32'd0);
                check("idle_data_released", {16'b0, data}, 32'd0);
            end
        end
    endtask

    task automatic do_txn(input logic [2:0] c, input logic [14:0] ts, input logic [3:0] off,
                          input logic [15:0] wlo, input logic [15:0] whi,
                          input logic [31:0] rd, input int delay, input bit stray,
                          input bit abort_lo);
        req_t r;
        req_t got;
        r.cmd   = c;
        r.addr  = {ts, off};
        r.wdata = model_wdata(c, wlo, whi);
        req_q.push_back(r);
        push_beats(c, rd);

        // First beat: command, tag+set, low write data.
        m_oe = 1'b1; m_cmd = c; address = ts; m_data = wlo;
        @(negedge clk);
        check("addr2_req_valid", {31'b0, req_valid}, 32'd0);
        // Second beat: offset and high write data; command is ignored here.
        address = {11'h0, off}; m_data = whi; m_cmd = 3'd1;
        @(negedge clk);
        m_oe = 1'b0;
        got = req_q.pop_front();
        check("req_valid", {31'b0, req_valid}, 32'd1);
        check("req_cmd", {29'b0, req_cmd}, {29'b0, got.cmd});
        check("req_addr", {13'b0, req_addr}, {13'b0, got.addr});
        check("req_wdata", req_wdata, got.wdata);
        for (int i = 0; i < delay; i++) begin
            req_ready = 1'b0;
            rsp_valid = stray;
            rsp_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            rsp_valid = 1'b0;
            check("hold_req_valid", {31'b0, req_valid}, 32'd1);
            check("hold_req_addr", {13'b0, req_addr}, {13'b0, got.addr});
            check("hold_req_cmd", {29'b0, req_cmd}, {29'b0, got.cmd});
            check("hold_cmd_released", {29'b0, command}, 32'd0);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check("wait_req_valid", {31'b0, req_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_rdata = rd;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        check("resp_lo_cmd", {29'b0, command}, 32'd7);
        if (abort_lo) begin
            reset = 1'b1;
            #1;
            check("abort_cmd_released", {29'b0, command}, 32'd0);
            check("abort_data_released", {16'b0, data}, 32'd0);
            check("abort_req_valid", {31'b0, req_valid}, 32'd0);
            check("abort_req_cmd", {29'b0, req_cmd}, 32'd0);
            check("abort_req_addr", {13'b0, req_addr}, 32'd0);
            check("abort_req_wdata", req_wdata, 32'd0);
            beat_q.delete();
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        for (int n = 0; n < 3 && command === 3'd7; n++) begin
            if (beat_q.size() == 0) begin
                check("extra_resp_beat", {29'b0, command}, 32'd0);
                break;
            end
            check("resp_data", {16'b0, data}, {16'b0, beat_q.pop_front()});
            @(negedge clk);
        end
        check("beats_left", beat_q.size(), 32'd0);
        check("end_cmd_released", {29'b0, command}, 32'd0);
        check("end_data_released", {16'b0, data}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; address = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        m_oe = 1'b0; m_cmd = 3'd0; m_data = 16'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_valid", {31'b0, req_valid}, 32'd0);
        check("rst_req_cmd", {29'b0, req_cmd}, 32'd0);
        check("rst_req_addr", {13'b0, req_addr}, 32'd0);
        check("rst_req_wdata", req_wdata, 32'd0);
        check("rst_cmd_released", {29'b0, command}, 32'd0);
        check("rst_data_released", {16'b0, data}, 32'd0);
        reset = 1'b0;

        // Released and NOP command lines with a stray core response: nothing happens.
        idle_cycles(2, 1'b1, 1'b0);
        idle_cycles(2, 1'b0, 1'b1);

        // WR32, RD32, RD8, then INV held off by req_ready with stray rsp_valid in REQ.
        do_txn(3'd7, 15'h000E, 4'h0, 16'h5555, 16'h5555, 32'h0000_1234, 0, 1'b0, 1'b0);
        do_txn(3'd3, 15'h000E, 4'h0, 16'h0000, 16'h0000, 32'hFFFF_0000, 0, 1'b0, 1'b0);
        do_txn(3'd1, 15'h0123, 4'h5, 16'h0000, 16'h0000, 32'h1234_56AB, 0, 1'b0, 1'b0);
        do_txn(3'd4, 15'h0011, 4'h0, 16'h0000, 16'h0000, 32'h0000_4321, 5, 1'b1, 1'b0);

        // Back-to-back WR16 and RD16, then WR8 masking and a top-of-range address.
        do_txn(3'd6, 15'h7FFF, 4'hF, 16'hA5C3, 16'h7777, 32'h0000_0BAD, 0, 1'b0, 1'b0);
        do_txn(3'd2, 15'h7FFF, 4'hF, 16'h0000, 16'h0000, 32'h9876_5432, 1, 1'b0, 1'b0);
        do_txn(3'd5, 15'h2AAA, 4'h3, 16'h1234, 16'hBEEF, 32'h0000_0F0F, 0, 1'b0, 1'b0);

        // Reset during RESP_LO of an RD32, then recovery.
        do_txn(3'd3, 15'h0040, 4'h8, 16'h0000, 16'h0000, 32'hAAAA_BBBB, 0, 1'b0, 1'b1);
        idle_cycles(2, 1'b1, 1'b0);
        do_txn(3'd2, 15'h0040, 4'h8, 16'h0000, 16'h0000, 32'h1111_2222, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
